// File: rtl/id_ex_hazard_reg_pkg.sv
// Shared widths, FSM encoding and the EX-stage field bundle for the ID/EX register.
// A bubble is the all-zero bundle.
package id_ex_hazard_reg_pkg;

  localparam int DATA_W = 16;
  localparam int REG_W  = 3;
  localparam int CTRL_W = 8;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_e;

  typedef struct packed {
    logic              valid;
    logic [REG_W-1:0]  rsrc;
    logic [REG_W-1:0]  rdst;
    logic [DATA_W-1:0] rsrc_val;
    logic [DATA_W-1:0] rdst_val;
    logic [DATA_W-1:0] imm;
    logic [CTRL_W-1:0] ctrl;
    logic              rdst1_wb;
    logic              rdst2_wb;
    logic              mem_read;
  } ex_fields_t;

  localparam logic [CTRL_W-1:0] BUBBLE_CTRL = '0;
  localparam ex_fields_t        BUBBLE      = '0;

endpackage

// File: rtl/id_ex_hazard_reg_if.sv
// ID-side inputs and EX-side outputs of the ID/EX register.
// The master is the surrounding pipeline; the slave is the register itself.
interface id_ex_hazard_reg_if #(
  parameter int PERF_W = 16
);
  import id_ex_hazard_reg_pkg::*;

  logic              flush_in;
  logic              freeze_in;
  logic              valid_ID_in;
  logic [REG_W-1:0]  Rsrc_ID_in;
  logic [REG_W-1:0]  Rdst_ID_in;
  logic              uses_Rsrc_ID_in;
  logic              uses_Rdst_ID_in;
  logic [DATA_W-1:0] Rsrc_val_ID_in;
  logic [DATA_W-1:0] Rdst_val_ID_in;
  logic [DATA_W-1:0] imm_ID_in;
  logic [CTRL_W-1:0] ctrl_ID_in;
  logic              Rdst1_wb_ID_in;
  logic              Rdst2_wb_ID_in;
  logic              mem_read_ID_in;

  logic              valid_EX_out;
  logic [REG_W-1:0]  Rsrc_EX_out;
  logic [REG_W-1:0]  Rdst_EX_out;
  logic [DATA_W-1:0] Rsrc_val_EX_out;
  logic [DATA_W-1:0] Rdst_val_EX_out;
  logic [DATA_W-1:0] imm_EX_out;
  logic [CTRL_W-1:0] ctrl_EX_out;
  logic              Rdst1_wb_EX_out;
  logic              Rdst2_wb_EX_out;
  logic              mem_read_EX_out;
  logic              stall_IF_ID_out;
  logic [PERF_W-1:0] bubble_cnt_out;

  modport master (
    output flush_in, freeze_in, valid_ID_in, Rsrc_ID_in, Rdst_ID_in, uses_Rsrc_ID_in,
           uses_Rdst_ID_in, Rsrc_val_ID_in, Rdst_val_ID_in, imm_ID_in, ctrl_ID_in,
           Rdst1_wb_ID_in, Rdst2_wb_ID_in, mem_read_ID_in,
    input  valid_EX_out, Rsrc_EX_out, Rdst_EX_out, Rsrc_val_EX_out, Rdst_val_EX_out,
           imm_EX_out, ctrl_EX_out, Rdst1_wb_EX_out, Rdst2_wb_EX_out, mem_read_EX_out,
           stall_IF_ID_out, bubble_cnt_out
  );

  modport slave (
    input  flush_in, freeze_in, valid_ID_in, Rsrc_ID_in, Rdst_ID_in, uses_Rsrc_ID_in,
           uses_Rdst_ID_in, Rsrc_val_ID_in, Rdst_val_ID_in, imm_ID_in, ctrl_ID_in,
           Rdst1_wb_ID_in, Rdst2_wb_ID_in, mem_read_ID_in,
    output valid_EX_out, Rsrc_EX_out, Rdst_EX_out, Rsrc_val_EX_out, Rdst_val_EX_out,
           imm_EX_out, ctrl_EX_out, Rdst1_wb_EX_out, Rdst2_wb_EX_out, mem_read_EX_out,
           stall_IF_ID_out, bubble_cnt_out
  );

endinterface

// File: rtl/id_ex_hazard_reg_load_use_detect.sv
// Combinational load-use compare: a load in EX whose Rdst1 is read by the valid
// instruction in ID. Dual-write instructions are never loads, so only Rdst1 matters.
module load_use_detect
  import id_ex_hazard_reg_pkg::*;
(
  input  logic             valid_ex,
  input  logic             mem_read_ex,
  input  logic             rdst1_wb_ex,
  input  logic [REG_W-1:0] rdst_ex,
  input  logic             valid_id,
  input  logic             uses_rsrc_id,
  input  logic [REG_W-1:0] rsrc_id,
  input  logic             uses_rdst_id,
  input  logic [REG_W-1:0] rdst_id,
  output logic             hazard
);

  logic src_hit;
  logic dst_hit;

  assign src_hit = uses_rsrc_id && (rsrc_id == rdst_ex);
  assign dst_hit = uses_rdst_id && (rdst_id == rdst_ex);
  assign hazard  = valid_ex && mem_read_ex && rdst1_wb_ex && valid_id && (src_hit || dst_hit);

endmodule

// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with load-use stall FSM and a saturating bubble counter.
// Per-cycle priority: flush, freeze, STALL state, hazard, normal load.
module id_ex_hazard_reg
  import id_ex_hazard_reg_pkg::*;
#(
  parameter int LU_STALL_CYCLES = 1,
  parameter int PERF_W          = 16
) (
  input logic               clk_in,
  input logic               reset_n_in,
  id_ex_hazard_reg_if.slave bus
);

  if (LU_STALL_CYCLES < 1 || LU_STALL_CYCLES > 3) begin : g_bad_lu
    $error("LU_STALL_CYCLES must be in 1..3");
  end

  ex_fields_t        ex_d, ex_q;
  ex_fields_t        id_fields;
  state_e            state_d, state_q;
  logic [1:0]        cnt_d, cnt_q;
  logic [PERF_W-1:0] bcnt_d, bcnt_q;
  logic [PERF_W-1:0] bcnt_inc;
  logic              hazard;
  logic              stall;

  assign id_fields = '{valid:    bus.valid_ID_in,
                       rsrc:     bus.Rsrc_ID_in,
                       rdst:     bus.Rdst_ID_in,
                       rsrc_val: bus.Rsrc_val_ID_in,
                       rdst_val: bus.Rdst_val_ID_in,
                       imm:      bus.imm_ID_in,
                       ctrl:     bus.ctrl_ID_in,
                       rdst1_wb: bus.Rdst1_wb_ID_in,
                       rdst2_wb: bus.Rdst2_wb_ID_in,
                       mem_read: bus.mem_read_ID_in};

  load_use_detect u_load_use_detect (
    .valid_ex     (ex_q.valid),
    .mem_read_ex  (ex_q.mem_read),
    .rdst1_wb_ex  (ex_q.rdst1_wb),
    .rdst_ex      (ex_q.rdst),
    .valid_id     (bus.valid_ID_in),
    .uses_rsrc_id (bus.uses_Rsrc_ID_in),
    .rsrc_id      (bus.Rsrc_ID_in),
    .uses_rdst_id (bus.uses_Rdst_ID_in),
    .rdst_id      (bus.Rdst_ID_in),
    .hazard       (hazard)
  );

  assign bcnt_inc = (&bcnt_q) ? bcnt_q : bcnt_q + 1'b1;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch behind.
    ex_d    = ex_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    bcnt_d  = bcnt_q;
    stall   = 1'b0;
    if (bus.flush_in) begin
      ex_d    = BUBBLE;
      state_d = RUN;
      cnt_d   = '0;
    end else if (bus.freeze_in) begin
      stall = 1'b1;
    end else if (state_q == STALL) begin
      ex_d   = BUBBLE;
      stall  = 1'b1;
      bcnt_d = bcnt_inc;
      cnt_d  = cnt_q - 2'd1;
      if (cnt_q == 2'd1) state_d = RUN;
    end else if (hazard) begin
      ex_d   = BUBBLE;
      stall  = 1'b1;
      bcnt_d = bcnt_inc;
      // With a single bubble the load leaves EX this edge and the hazard clears itself.
      if (LU_STALL_CYCLES > 1) begin
        state_d = STALL;
        cnt_d   = 2'(LU_STALL_CYCLES - 1);
      end
    end else begin
      ex_d = id_fields;
    end
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset_n_in) begin
      ex_q    <= BUBBLE;
      state_q <= RUN;
      cnt_q   <= '0;
      bcnt_q  <= '0;
    end else begin
      ex_q    <= ex_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bcnt_q  <= bcnt_d;
    end
  end

  assign bus.valid_EX_out    = ex_q.valid;
  assign bus.Rsrc_EX_out     = ex_q.rsrc;
  assign bus.Rdst_EX_out     = ex_q.rdst;
  assign bus.Rsrc_val_EX_out = ex_q.rsrc_val;
  assign bus.Rdst_val_EX_out = ex_q.rdst_val;
  assign bus.imm_EX_out      = ex_q.imm;
  assign bus.ctrl_EX_out     = ex_q.ctrl;
  assign bus.Rdst1_wb_EX_out = ex_q.rdst1_wb;
  assign bus.Rdst2_wb_EX_out = ex_q.rdst2_wb;
  assign bus.mem_read_EX_out = ex_q.mem_read;
  assign bus.stall_IF_ID_out = stall;
  assign bus.bubble_cnt_out  = bcnt_q;

endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// Directed bench: dut1 (1 bubble, 16-bit counter) and dut3 (3 bubbles, 2-bit counter so
// saturation is reachable) share the same ID stimulus; each vector checks one of them.
module tb_id_ex_hazard_reg;
  import id_ex_hazard_reg_pkg::*;

  localparam int NOP = 0, ADD = 1, LDM = 2, USE = 3, USED = 4, SWP = 5, NORD = 6, LDNW = 7, INV = 8;

  typedef struct {
    ex_fields_t f;
    logic       uses_rsrc;
    logic       uses_rdst;
  } instr_t;

  typedef struct {
    bit sel;        // 0: dut1, 1: dut3
    bit flush;
    bit freeze;
    int id;         // instruction presented in ID
    bit exp_stall;  // combinational stall with these inputs
    int exp_ex;     // instruction expected in EX before the coming edge (NOP == bubble)
    int exp_cnt;
  } vec_t;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  int     errors = 0;
  int     checks = 0;
  instr_t instr[9];
  vec_t   tbl[26];
  ex_fields_t act_ex1, act_ex3;

  always #5 clk = ~clk;

  id_ex_hazard_reg_if #(.PERF_W(16)) bus1 ();
  id_ex_hazard_reg_if #(.PERF_W(2))  bus3 ();

  id_ex_hazard_reg #(.LU_STALL_CYCLES(1), .PERF_W(16)) dut1 (
    .clk_in(clk), .reset_n_in(rst_n), .bus(bus1));
  id_ex_hazard_reg #(.LU_STALL_CYCLES(3), .PERF_W(2)) dut3 (
    .clk_in(clk), .reset_n_in(rst_n), .bus(bus3));

  assign bus3.flush_in        = bus1.flush_in;
  assign bus3.freeze_in       = bus1.freeze_in;
  assign bus3.valid_ID_in     = bus1.valid_ID_in;
  assign bus3.Rsrc_ID_in      = bus1.Rsrc_ID_in;
  assign bus3.Rdst_ID_in      = bus1.Rdst_ID_in;
  assign bus3.uses_Rsrc_ID_in = bus1.uses_Rsrc_ID_in;
  assign bus3.uses_Rdst_ID_in = bus1.uses_Rdst_ID_in;
  assign bus3.Rsrc_val_ID_in  = bus1.Rsrc_val_ID_in;
  assign bus3.Rdst_val_ID_in  = bus1.Rdst_val_ID_in;
  assign bus3.imm_ID_in       = bus1.imm_ID_in;
  assign bus3.ctrl_ID_in      = bus1.ctrl_ID_in;
  assign bus3.Rdst1_wb_ID_in  = bus1.Rdst1_wb_ID_in;
  assign bus3.Rdst2_wb_ID_in  = bus1.Rdst2_wb_ID_in;
  assign bus3.mem_read_ID_in  = bus1.mem_read_ID_in;

  assign act_ex1 = {bus1.valid_EX_out, bus1.Rsrc_EX_out, bus1.Rdst_EX_out, bus1.Rsrc_val_EX_out,
                    bus1.Rdst_val_EX_out, bus1.imm_EX_out, bus1.ctrl_EX_out,
                    bus1.Rdst1_wb_EX_out, bus1.Rdst2_wb_EX_out, bus1.mem_read_EX_out};
  assign act_ex3 = {bus3.valid_EX_out, bus3.Rsrc_EX_out, bus3.Rdst_EX_out, bus3.Rsrc_val_EX_out,
                    bus3.Rdst_val_EX_out, bus3.imm_EX_out, bus3.ctrl_EX_out,
                    bus3.Rdst1_wb_EX_out, bus3.Rdst2_wb_EX_out, bus3.mem_read_EX_out};

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input bit flush, input bit freeze, input int id);
    bus1.flush_in        = flush;
    bus1.freeze_in       = freeze;
    bus1.valid_ID_in     = instr[id].f.valid;
    bus1.Rsrc_ID_in      = instr[id].f.rsrc;
    bus1.Rdst_ID_in      = instr[id].f.rdst;
    bus1.uses_Rsrc_ID_in = instr[id].uses_rsrc;
    bus1.uses_Rdst_ID_in = instr[id].uses_rdst;
    bus1.Rsrc_val_ID_in  = instr[id].f.rsrc_val;
    bus1.Rdst_val_ID_in  = instr[id].f.rdst_val;
    bus1.imm_ID_in       = instr[id].f.imm;
    bus1.ctrl_ID_in      = instr[id].f.ctrl;
    bus1.Rdst1_wb_ID_in  = instr[id].f.rdst1_wb;
    bus1.Rdst2_wb_ID_in  = instr[id].f.rdst2_wb;
    bus1.mem_read_ID_in  = instr[id].f.mem_read;
  endtask

  // Drive at the falling edge, sample 1 ns later: EX shows the result of the last rising edge.
  task automatic step(input vec_t v, input string tag);
    logic       stall_a;
    ex_fields_t ex_a;
    int         cnt_a;
    @(negedge clk);
    drive(v.flush, v.freeze, v.id);
    #1;
    if (v.sel) begin
      stall_a = bus3.stall_IF_ID_out; ex_a = act_ex3; cnt_a = int'(bus3.bubble_cnt_out);
    end else begin
      stall_a = bus1.stall_IF_ID_out; ex_a = act_ex1; cnt_a = int'(bus1.bubble_cnt_out);
    end
    check({tag, " stall"}, 80'(stall_a), 80'(v.exp_stall));
    check({tag, " ex"}, 80'(ex_a), 80'(instr[v.exp_ex].f));
    check({tag, " bubble_cnt"}, 80'(cnt_a), 80'(v.exp_cnt));
  endtask

  // Asynchronous reset asserted between clock edges, with `id` left in ID.
  task automatic reset_check(input string tag, input int id);
    @(negedge clk);
    #2;
    drive(1'b0, 1'b0, id);
    rst_n = 1'b0;
    #1;
    check({tag, " dut1 ex"}, 80'(act_ex1), 80'(0));
    check({tag, " dut1 cnt"}, 80'(bus1.bubble_cnt_out), 80'(0));
    check({tag, " dut1 stall"}, 80'(bus1.stall_IF_ID_out), 80'(0));
    check({tag, " dut3 ex"}, 80'(act_ex3), 80'(0));
    check({tag, " dut3 cnt"}, 80'(bus3.bubble_cnt_out), 80'(0));
    check({tag, " dut3 stall"}, 80'(bus3.stall_IF_ID_out), 80'(0));
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    //                 valid rsrc  rdst  rsrc_val  rdst_val  imm       ctrl   wb1   wb2   mrd    uses_s uses_d
    instr[NOP]  = '{'{1'b0, 3'd0, 3'd0, 16'h0000, 16'h0000, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0}, 1'b0, 1'b0};
    instr[ADD]  = '{'{1'b1, 3'd2, 3'd1, 16'h1234, 16'h0005, 16'h0000, 8'h11, 1'b1, 1'b0, 1'b0}, 1'b1, 1'b1};
    instr[LDM]  = '{'{1'b1, 3'd0, 3'd3, 16'h0000, 16'h0000, 16'h00A0, 8'h22, 1'b1, 1'b0, 1'b1}, 1'b0, 1'b0};
    instr[USE]  = '{'{1'b1, 3'd3, 3'd4, 16'h0003, 16'h0044, 16'h0000, 8'h33, 1'b1, 1'b0, 1'b0}, 1'b1, 1'b1};
    instr[USED] = '{'{1'b1, 3'd5, 3'd3, 16'h0055, 16'h0333, 16'h0000, 8'h44, 1'b1, 1'b0, 1'b0}, 1'b1, 1'b1};
    instr[SWP]  = '{'{1'b1, 3'd3, 3'd2, 16'hAAAA, 16'h5555, 16'h0000, 8'h55, 1'b1, 1'b1, 1'b0}, 1'b1, 1'b1};
    instr[NORD] = '{'{1'b1, 3'd3, 3'd6, 16'h0000, 16'h0000, 16'h0077, 8'h66, 1'b1, 1'b0, 1'b0}, 1'b0, 1'b0};
    instr[LDNW] = '{'{1'b1, 3'd0, 3'd3, 16'h0000, 16'h0000, 16'h00B0, 8'h77, 1'b0, 1'b0, 1'b1}, 1'b0, 1'b0};
    instr[INV]  = '{'{1'b0, 3'd3, 3'd5, 16'h0009, 16'h0008, 16'h0000, 8'h88, 1'b1, 1'b0, 1'b0}, 1'b1, 1'b0};

    // dut1 (one bubble per load-use)  sel flush frz  id    stall ex    cnt
    tbl = '{
      '{1'b0, 1'b0, 1'b0, ADD,  1'b0, NOP,  0},
      '{1'b0, 1'b0, 1'b0, LDM,  1'b0, ADD,  0},
      '{1'b0, 1'b0, 1'b0, USE,  1'b1, LDM,  0},
      '{1'b0, 1'b0, 1'b0, USE,  1'b0, NOP,  1},
      '{1'b0, 1'b0, 1'b0, LDM,  1'b0, USE,  1},
      '{1'b0, 1'b0, 1'b0, USED, 1'b1, LDM,  1},
      '{1'b0, 1'b0, 1'b0, USED, 1'b0, NOP,  2},
      '{1'b0, 1'b0, 1'b0, LDM,  1'b0, USED, 2},
      '{1'b0, 1'b0, 1'b0, NORD, 1'b0, LDM,  2},
      '{1'b0, 1'b0, 1'b0, LDM,  1'b0, NORD, 2},
      '{1'b0, 1'b0, 1'b0, INV,  1'b0, LDM,  2},
      '{1'b0, 1'b0, 1'b0, LDNW, 1'b0, INV,  2},
      '{1'b0, 1'b0, 1'b0, USE,  1'b0, LDNW, 2},
      '{1'b0, 1'b0, 1'b0, SWP,  1'b0, USE,  2},
      '{1'b0, 1'b1, 1'b0, ADD,  1'b0, SWP,  2},
      '{1'b0, 1'b0, 1'b0, ADD,  1'b0, NOP,  2},
      '{1'b0, 1'b0, 1'b0, LDM,  1'b0, ADD,  2},
      '{1'b0, 1'b1, 1'b0, USE,  1'b0, LDM,  2},
      '{1'b0, 1'b0, 1'b0, USE,  1'b0, NOP,  2},
      '{1'b0, 1'b0, 1'b0, NOP,  1'b0, USE,  2},
      '{1'b0, 1'b0, 1'b0, LDM,  1'b0, NOP,  2},
      '{1'b0, 1'b0, 1'b1, USE,  1'b1, LDM,  2},
      '{1'b0, 1'b0, 1'b1, USE,  1'b1, LDM,  2},
      '{1'b0, 1'b0, 1'b0, USE,  1'b1, LDM,  2},
      '{1'b0, 1'b0, 1'b0, USE,  1'b0, NOP,  3},
      '{1'b0, 1'b0, 1'b0, NOP,  1'b0, USE,  3}
    };

    drive(1'b0, 1'b0, NOP);
    reset_check("init", NOP);

    for (int i = 0; i < $size(tbl); i++) step(tbl[i], $sformatf("v%0d", i));

    reset_check("mid_run", NOP);

    // dut3: three bubbles per hazard, then saturation of its 2-bit counter
    step('{1'b1, 1'b0, 1'b0, LDM, 1'b0, NOP, 0}, "b0");
    step('{1'b1, 1'b0, 1'b0, USE, 1'b1, LDM, 0}, "b1");
    step('{1'b1, 1'b0, 1'b0, USE, 1'b1, NOP, 1}, "b2");
    step('{1'b1, 1'b0, 1'b0, USE, 1'b1, NOP, 2}, "b3");
    step('{1'b1, 1'b0, 1'b0, USE, 1'b0, NOP, 3}, "b4");
    step('{1'b1, 1'b0, 1'b0, NOP, 1'b0, USE, 3}, "b5");
    step('{1'b1, 1'b0, 1'b0, LDM, 1'b0, NOP, 3}, "b6");
    step('{1'b1, 1'b0, 1'b0, USE, 1'b1, LDM, 3}, "b7");
    step('{1'b1, 1'b0, 1'b0, USE, 1'b1, NOP, 3}, "b8");
    step('{1'b1, 1'b0, 1'b0, USE, 1'b1, NOP, 3}, "b9");
    step('{1'b1, 1'b0, 1'b0, USE, 1'b0, NOP, 3}, "b10");
    step('{1'b1, 1'b0, 1'b0, NOP, 1'b0, USE, 3}, "b11");

    reset_check("b_to_c", NOP);

    // dut3: flush in the second STALL-state cycle
    step('{1'b1, 1'b0, 1'b0, LDM, 1'b0, NOP, 0}, "c0");
    step('{1'b1, 1'b0, 1'b0, USE, 1'b1, LDM, 0}, "c1");
    step('{1'b1, 1'b0, 1'b0, USE, 1'b1, NOP, 1}, "c2");
    step('{1'b1, 1'b1, 1'b0, USE, 1'b0, NOP, 2}, "c3");
    step('{1'b1, 1'b0, 1'b0, ADD, 1'b0, NOP, 2}, "c4");
    step('{1'b1, 1'b0, 1'b0, NOP, 1'b0, ADD, 2}, "c5");

    // dut3: freeze on the hazard cycle and inside STALL, then resume
    step('{1'b1, 1'b0, 1'b0, LDM, 1'b0, NOP, 2}, "d0");
    step('{1'b1, 1'b0, 1'b1, USE, 1'b1, LDM, 2}, "d1");
    step('{1'b1, 1'b0, 1'b0, USE, 1'b1, LDM, 2}, "d2");
    step('{1'b1, 1'b0, 1'b1, USE, 1'b1, NOP, 3}, "d3");
    step('{1'b1, 1'b0, 1'b1, USE, 1'b1, NOP, 3}, "d4");
    step('{1'b1, 1'b0, 1'b0, USE, 1'b1, NOP, 3}, "d5");
    step('{1'b1, 1'b0, 1'b0, USE, 1'b1, NOP, 3}, "d6");
    step('{1'b1, 1'b0, 1'b0, USE, 1'b0, NOP, 3}, "d7");
    step('{1'b1, 1'b0, 1'b0, NOP, 1'b0, USE, 3}, "d8");

    // dut3: reset lands in the middle of a stall
    step('{1'b1, 1'b0, 1'b0, LDM, 1'b0, NOP, 3}, "e0");
    step('{1'b1, 1'b0, 1'b0, USE, 1'b1, LDM, 3}, "e1");
    step('{1'b1, 1'b0, 1'b0, USE, 1'b1, NOP, 3}, "e2");
    reset_check("mid_stall", USE);
    step('{1'b1, 1'b0, 1'b0, NOP, 1'b0, USE, 0}, "e3");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
